apb4_master_fsm: RTL and testbench

//  APB4 requester stage that sits directly upstream of the APB bridge interface and drives PADDR/PPROT/PSELx/

---
 rtl/apb4_master_fsm_if.sv | 51 +++++
 rtl/apb4_master_fsm.sv | 160 ++++++++++++++++
 tb/tb_apb4_master_fsm.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_master_fsm_if.sv
// Command/response handshake and APB4 bus bundle for apb4_master_fsm.
// The master modport is the FSM's side of every signal. The slave modport is
// the mirror image, used by whatever drives commands and plays the completer.
interface apb4_master_fsm_if #(
  parameter int NO_OF_SLAVE = 4
);
  // command port
  logic                   req_valid;
  logic                   req_ready;
  logic [31:0]            req_addr;
  logic                   req_write;
  logic [31:0]            req_wdata;
  logic [3:0]             req_strb;
  logic [2:0]             req_prot;
  // response port
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [31:0]            rsp_rdata;
  logic                   rsp_err;
  logic                   rsp_timeout;
  // APB4 request
  logic [31:0]            PADDR;
  logic [2:0]             PPROT;
  logic [NO_OF_SLAVE-1:0] PSELx;
  logic                   PWRITE;
  logic                   PENABLE;
  logic [31:0]            PWDATA;
  logic [3:0]             PSTRB;
  // APB4 completer response
  logic                   PREADY;
  logic [31:0]            PRDATA;
  logic                   PSLVERR;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
    input  rsp_ready,
    input  PREADY, PRDATA, PSLVERR,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PADDR, PPROT, PSELx, PWRITE, PENABLE, PWDATA, PSTRB
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
    output rsp_ready,
    output PREADY, PRDATA, PSLVERR,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PADDR, PPROT, PSELx, PWRITE, PENABLE, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb4_master_fsm.sv
// APB4 requester: takes one command at a time, decodes the slave select from
// the address, runs SETUP/ACCESS on the bus, absorbs PREADY wait states with a
// timeout, and hands PRDATA/PSLVERR back on a valid/ready response port.
// Every output is a flop; nothing on the APB side reaches an output
// combinationally.
module apb4_master_fsm #(
  parameter int NO_OF_SLAVE = 4,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT     = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb4_master_fsm_if.master bus
);
  // One extra index bit beyond what NO_OF_SLAVE needs, so addresses just
  // past the last slave decode as out of range instead of aliasing.
  localparam int IDX_W = $clog2(NO_OF_SLAVE) + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   req_ready_q;
  logic                   dec_err_q;
  logic [CNT_W-1:0]       wait_cnt_q;

  logic [31:0]            paddr_q;
  logic [2:0]             pprot_q;
  logic [NO_OF_SLAVE-1:0] psel_q;
  logic                   pwrite_q;
  logic                   penable_q;
  logic [31:0]            pwdata_q;
  logic [3:0]             pstrb_q;

  logic                   rsp_valid_q;
  logic [31:0]            rsp_rdata_q;
  logic                   rsp_err_q;
  logic                   rsp_timeout_q;

  // Slave decode of the incoming command address.
  logic [IDX_W-1:0]       sel_idx_d;
  logic                   sel_hit_d;
  logic [NO_OF_SLAVE-1:0] sel_onehot_d;

  assign sel_idx_d = bus.req_addr[SEL_LSB +: IDX_W];
  assign sel_hit_d = (32'(sel_idx_d) < 32'(NO_OF_SLAVE));

  generate
    for (genvar gi = 0; gi < NO_OF_SLAVE; gi++) begin : g_sel
      assign sel_onehot_d[gi] = (32'(sel_idx_d) == 32'(gi));
    end
  endgenerate

  // Transfer sequencer. A decode error still spends one cycle in SETUP (with
  // the bus untouched) so its response arrives one cycle after acceptance,
  // never with PSELx asserted.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      dec_err_q     <= 1'b0;
      wait_cnt_q    <= '0;
      paddr_q       <= '0;
      pprot_q       <= '0;
      psel_q        <= '0;
      pwrite_q      <= 1'b0;
      penable_q     <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            dec_err_q   <= !sel_hit_d;
            state_q     <= SETUP;
            if (sel_hit_d) begin
              psel_q   <= sel_onehot_d;
              paddr_q  <= bus.req_addr;
              pwrite_q <= bus.req_write;
              pprot_q  <= bus.req_prot;
              pwdata_q <= bus.req_write ? bus.req_wdata : 32'h0;
              pstrb_q  <= bus.req_write ? bus.req_strb : 4'h0;
            end
          end
        end

        SETUP: begin
          if (dec_err_q) begin
            state_q       <= RESP;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
          end else begin
            state_q    <= ACCESS;
            penable_q  <= 1'b1;
            wait_cnt_q <= '0;
          end
        end

        ACCESS: begin
          if (bus.PREADY) begin
            state_q       <= RESP;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= bus.PSLVERR;
            rsp_timeout_q <= 1'b0;
            // Read data is only meaningful for a successful read.
            rsp_rdata_q   <= (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : 32'h0;
          end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q       <= RESP;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PPROT       = pprot_q;
  assign bus.PSELx       = psel_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
endmodule

// File: tb/tb_apb4_master_fsm.sv
// Self-checking bench for apb4_master_fsm: directed vector table, a
// mid-transfer reset sequence and randomized transactions scored against a
// behavioural model of the transfer rules.
module tb_apb4_master_fsm;
  localparam int NSLV = 4;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb4_master_fsm_if #(.NO_OF_SLAVE(NSLV)) bus ();

  apb4_master_fsm #(
    .NO_OF_SLAVE(NSLV),
    .SEL_LSB    (12),
    .TIMEOUT    (TMO)
  ) dut (
    .PCLK   (clk),
    .PRESETn(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;   // ACCESS cycles with PREADY=0 before PREADY=1
    logic [31:0] prdata;
    logic        slverr;
    int          hold;    // cycles rsp_ready is held low once rsp_valid is up
  } txn_t;

  typedef struct {
    logic [3:0]  psel;    // PSELx value expected during SETUP/ACCESS (0 = none)
    int          lat;     // cycles from accept edge to first rsp_valid
    logic        err;
    logic        to;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    txn_t t;
    exp_t e;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model: slave index is the 3-bit field at byte offset 4 KiB,
  // each ACCESS cycle either completes or burns one of TMO allowed waits.
  function automatic exp_t ref_model(input txn_t t);
    exp_t e;
    int   idx;
    logic decode_err;
    logic timed_out;
    idx        = int'((t.addr / 32'd4096) % 32'd8);
    decode_err = (idx >= NSLV);
    timed_out  = !decode_err && (t.waits >= TMO);
    e.psel     = decode_err ? 4'd0 : 4'(1 << idx);
    if (decode_err)     e.lat = 2;
    else if (timed_out) e.lat = 2 + TMO;
    else                e.lat = 3 + t.waits;
    e.err   = decode_err || timed_out || t.slverr;
    e.to    = timed_out;
    e.rdata = (e.err || t.write) ? 32'h0 : t.prdata;
    return e;
  endfunction

  function automatic vec_t mkv(
    input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
    input logic [3:0] strb, input logic [2:0] prot, input int waits,
    input logic [31:0] prdata, input logic slverr, input int hold,
    input logic [3:0] epsel, input int elat, input logic eerr,
    input logic eto, input logic [31:0] erdata);
    vec_t v;
    v.t.addr = addr;   v.t.write = wr;    v.t.wdata = wdata;
    v.t.strb = strb;   v.t.prot = prot;   v.t.waits = waits;
    v.t.prdata = prdata; v.t.slverr = slverr; v.t.hold = hold;
    v.e.psel = epsel;  v.e.lat = elat;    v.e.err = eerr;
    v.e.to = eto;      v.e.rdata = erdata;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one command, play the completer, and score the whole transfer.
  // Entered and left 1 time unit after a rising edge.
  task automatic run_txn(input txn_t t, input exp_t e, input string tag);
    logic        accepted;
    logic [3:0]  psel_seen;
    int          lat;
    int          acc;
    int          proto_bad;
    int          stable_bad;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_to;

    bus.req_valid = 1'b1;
    bus.req_addr  = t.addr;
    bus.req_write = t.write;
    bus.req_wdata = t.wdata;
    bus.req_strb  = t.strb;
    bus.req_prot  = t.prot;
    accepted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      accepted = bus.req_ready;
      step();
      if (accepted) break;
    end
    chk({tag, " accept"}, 32'(accepted), 32'd1);
    // Scramble the command port: the DUT must work from its registered copy.
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_write = 1'($urandom);
    bus.req_wdata = $urandom;
    bus.req_strb  = 4'($urandom);
    bus.req_prot  = 3'($urandom);
    if (!accepted) return;

    lat = 0; acc = 0; proto_bad = 0; psel_seen = '0;
    r_rdata = '0; r_err = 1'b0; r_to = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      psel_seen = psel_seen | bus.PSELx;
      if (bus.req_ready) proto_bad++;
      if (bus.rsp_valid) begin
        lat     = k;
        r_rdata = bus.rsp_rdata;
        r_err   = bus.rsp_err;
        r_to    = bus.rsp_timeout;
        if (bus.PSELx != 0 || bus.PENABLE) proto_bad++;
        break;
      end
      if (bus.PSELx != e.psel) proto_bad++;
      if (bus.PENABLE !== ((k >= 2) && (e.psel != 0))) proto_bad++;
      if (bus.PSELx != 0) begin
        if (bus.PADDR  !== t.addr)  proto_bad++;
        if (bus.PWRITE !== t.write) proto_bad++;
        if (bus.PPROT  !== t.prot)  proto_bad++;
        if (bus.PWDATA !== (t.write ? t.wdata : 32'h0)) proto_bad++;
        if (bus.PSTRB  !== (t.write ? t.strb : 4'h0))   proto_bad++;
      end
      if (bus.PSELx != 0 && bus.PENABLE) begin
        bus.PREADY  = (acc == t.waits);
        acc++;
        bus.PSLVERR = bus.PREADY ? t.slverr : 1'($urandom);
        bus.PRDATA  = bus.PREADY ? t.prdata : $urandom;
      end else begin
        // Completer noise outside ACCESS must be ignored.
        bus.PREADY  = 1'($urandom);
        bus.PSLVERR = 1'($urandom);
        bus.PRDATA  = $urandom;
      end
      step();
    end
    bus.PREADY = 1'b0;

    stable_bad = 0;
    if (lat != 0) begin
      for (int h = 0; h < t.hold; h++) begin
        step();
        if (!bus.rsp_valid || bus.rsp_rdata !== r_rdata || bus.rsp_err !== r_err ||
            bus.rsp_timeout !== r_to || bus.req_ready || bus.PSELx != 0 || bus.PENABLE)
          stable_bad++;
      end
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    if (bus.rsp_valid) stable_bad++;
    if (!bus.req_ready) stable_bad++;

    $display("txn %s addr=%08h wr=%0d waits=%0d hold=%0d -> psel=%b lat=%0d err=%0d to=%0d rdata=%08h",
             tag, t.addr, t.write, t.waits, t.hold, psel_seen, lat, r_err, r_to, r_rdata);
    chk({tag, " psel"},      32'(psel_seen), 32'(e.psel));
    chk({tag, " latency"},   32'(lat),       32'(e.lat));
    chk({tag, " rsp_err"},   32'(r_err),     32'(e.err));
    chk({tag, " rsp_to"},    32'(r_to),      32'(e.to));
    chk({tag, " rsp_rdata"}, r_rdata,        e.rdata);
    chk({tag, " protocol"},  32'(proto_bad), 32'd0);
    chk({tag, " rsp_hold"},  32'(stable_bad), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    exp_t e;
    logic ok;

    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0;
    bus.req_wdata = '0;   bus.req_strb = '0; bus.req_prot = '0;
    bus.rsp_ready = 1'b0; bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk("reset PSELx",     32'(bus.PSELx),     32'd0);
    chk("reset PENABLE",   32'(bus.PENABLE),   32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset PADDR",     bus.PADDR,          32'd0);
    chk("reset rsp_err",   32'(bus.rsp_err),   32'd0);
    rst_n = 1'b1;
    step();
    chk("post-reset req_ready", 32'(bus.req_ready), 32'd1);

    // Directed table: addr wr wdata strb prot waits prdata slverr hold | psel lat err to rdata
    vecs.push_back(mkv(32'h0000_1004, 1, 32'hDEAD_BEEF, 4'hF, 3'd2,  0, 32'hA5A5_A5A5, 0, 0, 4'b0010,  3, 0, 0, 32'h0));
    vecs.push_back(mkv(32'h0000_3010, 0, 32'h1111_1111, 4'hF, 3'd0,  3, 32'h1234_5678, 0, 1, 4'b1000,  6, 0, 0, 32'h1234_5678));
    vecs.push_back(mkv(32'h0000_5000, 0, 32'h0,         4'h0, 3'd0,  0, 32'h5555_5555, 0, 0, 4'b0000,  2, 1, 0, 32'h0));
    vecs.push_back(mkv(32'h0000_2000, 0, 32'h0,         4'h0, 3'd5, 40, 32'hCAFE_F00D, 0, 0, 4'b0100, 18, 1, 1, 32'h0));
    vecs.push_back(mkv(32'h0000_0008, 1, 32'h0BAD_F00D, 4'h5, 3'd1,  0, 32'h0,         1, 5, 4'b0001,  3, 1, 0, 32'h0));
    vecs.push_back(mkv(32'h0000_2FFC, 0, 32'h0,         4'h3, 3'd7, 15, 32'h600D_CAFE, 0, 0, 4'b0100, 18, 0, 0, 32'h600D_CAFE));
    vecs.push_back(mkv(32'h0000_4000, 1, 32'h1234_0000, 4'hF, 3'd0,  0, 32'h0,         0, 2, 4'b0000,  2, 1, 0, 32'h0));
    vecs.push_back(mkv(32'h0001_3000, 0, 32'h0,         4'h0, 3'd4,  1, 32'h0F0F_0F0F, 0, 0, 4'b1000,  4, 0, 0, 32'h0F0F_0F0F));
    vecs.push_back(mkv(32'h0000_1FF0, 0, 32'h0,         4'h0, 3'd0,  2, 32'h7777_7777, 1, 0, 4'b0010,  5, 1, 0, 32'h0));
    vecs.push_back(mkv(32'h0000_0000, 1, 32'hFFFF_0000, 4'hC, 3'd3, 16, 32'h0,         0, 0, 4'b0001, 18, 1, 1, 32'h0));
    for (int i = 0; i < vecs.size(); i++)
      run_txn(vecs[i].t, vecs[i].e, $sformatf("vec%0d", i));

    // Reset in the middle of ACCESS drops the transfer silently
    bus.req_valid = 1'b1; bus.req_addr = 32'h0000_1000; bus.req_write = 1'b0;
    bus.req_wdata = '0;   bus.req_strb = '0;            bus.req_prot = '0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ok = bus.req_ready;
      step();
      if (ok) break;
    end
    bus.req_valid = 1'b0;
    bus.PREADY = 1'b0;
    chk("midrst accept", 32'(ok), 32'd1);
    step();
    step();
    chk("midrst in ACCESS", 32'({bus.PSELx, bus.PENABLE}), 32'b00101);
    rst_n = 1'b0;
    step();
    chk("midrst PSELx",     32'(bus.PSELx),     32'd0);
    chk("midrst PENABLE",   32'(bus.PENABLE),   32'd0);
    chk("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst req_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    step();
    step();
    bus.rsp_ready = 1'b0;
    chk("midrst no response", 32'({bus.rsp_valid, bus.PSELx}), 32'd0);
    chk("midrst req_ready",   32'(bus.req_ready),               32'd1);
    run_txn(vecs[0].t, vecs[0].e, "after-reset");

    // Randomized transactions against the behavioural model
    for (int n = 0; n < 40; n++) begin
      t.addr   = ($urandom & 32'hFFFF_8FFF) | (32'($urandom_range(0, 7)) << 12);
      t.write  = 1'($urandom);
      t.wdata  = $urandom;
      t.strb   = 4'($urandom);
      t.prot   = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       t.waits = 0;
        1:       t.waits = $urandom_range(1, 4);
        2:       t.waits = $urandom_range(14, 17);
        default: t.waits = 40;
      endcase
      t.prdata = $urandom;
      t.slverr = ($urandom_range(0, 3) == 0);
      t.hold   = $urandom_range(0, 3);
      e = ref_model(t);
      run_txn(t, e, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
